// File: rtl/axi4lite_master.sv
// AXI4-Lite master with one outstanding transaction, driven by a cmd/rsp handshake.
// Define AXI_MASTER_TIMEOUT_EN to abort transactions stalled for TIMEOUT_CYCLES cycles.
module axi4lite_master #(
    parameter int AXIS_ADDR_WIDTH = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIS_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIS_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [AXIS_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,
    output logic [AXIS_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                   M_AXI_AWPROT,
    output logic                         M_AXI_AWVALID,
    input  logic                         M_AXI_AWREADY,
    output logic [AXIS_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [AXIS_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                         M_AXI_WVALID,
    input  logic                         M_AXI_WREADY,
    input  logic [1:0]                   M_AXI_BRESP,
    input  logic                         M_AXI_BVALID,
    output logic                         M_AXI_BREADY,
    output logic [AXIS_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                   M_AXI_ARPROT,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [AXIS_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    state_t state;
    logic   aw_ok;
    logic   w_ok;
    logic   done_now;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // A write channel counts as accepted once its VALID has dropped or is handshaking now.
    always_comb begin
        aw_ok    = !M_AXI_AWVALID || M_AXI_AWREADY;
        w_ok     = !M_AXI_WVALID || M_AXI_WREADY;
        done_now = 1'b0;
        case (state)
            WR_REQ:  done_now = aw_ok && w_ok;
            WR_RESP: done_now = M_AXI_BVALID;
            RD_REQ:  done_now = M_AXI_ARREADY;
            RD_RESP: done_now = M_AXI_RVALID;
            default: done_now = 1'b0;
        endcase
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_wait;

    assign in_wait = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            tmo_cnt       <= '0;
            rsp_timeout   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            state         <= WR_REQ;
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= RD_REQ;
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (done_now) begin
                        state        <= WR_RESP;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (done_now) begin
                        state        <= RSP;
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                    end
                end
                RD_REQ: begin
                    if (done_now) begin
                        state         <= RD_RESP;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (done_now) begin
                        state        <= RSP;
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AXI_MASTER_TIMEOUT_EN
            // A completion in the final counted cycle wins over the abort.
            if (in_wait) begin
                if (!done_now && tmo_cnt == TMO_LAST) begin
                    state         <= RSP;
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_timeout   <= 1'b1;
                    rsp_resp      <= 2'b10;
                    rsp_rdata     <= '0;
                    tmo_cnt       <= '0;
                end else if (done_now && (state == WR_RESP || state == RD_RESP)) begin
                    rsp_timeout   <= 1'b0;
                    tmo_cnt       <= '0;
                end else begin
                    tmo_cnt       <= tmo_cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi4lite_master.sv
// Directed and randomized bench for axi4lite_master with a cycle-stepped AXI4-Lite slave model.
// Expected responses and latencies come from per-transaction slave settings.
module tb_axi4lite_master;
    localparam int TO = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axi4lite_master #(.AXIS_ADDR_WIDTH(32), .AXIS_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave settings for the current transaction
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          b_never;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    // Slave observations
    bit          txn_wr, aw_pend, w_pend, ar_pend;
    int          aw_vcyc, w_vcyc, ar_vcyc, aw_hs, w_hs, b_hs, ar_hs, r_hs, b_wait, r_wait, viol;
    int          aw_first, w_first, ar_first, bready_first, rready_first;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    task automatic cfg(input int aw, input int w, input int b, input int ar, input int r,
                       input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        s_bresp = br; s_rresp = rr; s_rdata = rd; b_never = 1'b0;
    endtask

    task automatic slave_clear(input bit wr);
        txn_wr = wr; aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        b_wait = 0; r_wait = 0; viol = 0;
        aw_first = -1; w_first = -1; ar_first = -1; bready_first = -1; rready_first = -1;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wstrb = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    endtask

    // One clock of the slave: observe outputs at the falling edge, drive inputs for the next rising edge.
    task automatic tick();
        @(negedge ACLK);
        if (txn_wr && (M_AXI_ARVALID || M_AXI_RREADY)) viol++;
        if (!txn_wr && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)) viol++;
        if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) viol++;
        M_AXI_BVALID = 1'b0;
        if (aw_hs > 0 && w_hs > 0 && b_hs == 0 && !b_never) begin
            M_AXI_BVALID = (b_wait >= b_dly); b_wait++;
        end
        M_AXI_BRESP = s_bresp;
        M_AXI_RVALID = 1'b0;
        if (ar_hs > 0 && r_hs == 0) begin
            M_AXI_RVALID = (r_wait >= r_dly); r_wait++;
        end
        M_AXI_RDATA = M_AXI_RVALID ? s_rdata : 32'h0;
        M_AXI_RRESP = s_rresp;
        if (M_AXI_BREADY && bready_first < 0) bready_first = cyc;
        if (M_AXI_RREADY && rready_first < 0) rready_first = cyc;

        if (aw_pend && !M_AXI_AWVALID) viol++;
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_vcyc >= aw_dly);
        if (M_AXI_AWVALID) begin
            if (aw_vcyc == 0) aw_first = cyc;
            else if (M_AXI_AWADDR !== s_awaddr) viol++;
            s_awaddr = M_AXI_AWADDR; aw_vcyc++;
        end
        aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs++;

        if (w_pend && !M_AXI_WVALID) viol++;
        M_AXI_WREADY = M_AXI_WVALID && (w_vcyc >= w_dly);
        if (M_AXI_WVALID) begin
            if (w_vcyc == 0) w_first = cyc;
            else if (M_AXI_WDATA !== s_wdata || M_AXI_WSTRB !== s_wstrb) viol++;
            s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; w_vcyc++;
        end
        w_pend = M_AXI_WVALID && !M_AXI_WREADY;
        if (M_AXI_WVALID && M_AXI_WREADY) w_hs++;

        if (ar_pend && !M_AXI_ARVALID) viol++;
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_vcyc >= ar_dly);
        if (M_AXI_ARVALID) begin
            if (ar_vcyc == 0) ar_first = cyc;
            else if (M_AXI_ARADDR !== s_araddr) viol++;
            s_araddr = M_AXI_ARADDR; ar_vcyc++;
        end
        ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
        if (M_AXI_ARVALID && M_AXI_ARREADY) ar_hs++;

        if (M_AXI_BVALID && M_AXI_BREADY) b_hs++;
        if (M_AXI_RVALID && M_AXI_RREADY) r_hs++;
    endtask

    // Issue one command, run it to completion, hold rsp_ready low for 'hold' cycles.
    task automatic run_txn(input string nm, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int hold);
        int          acc_cyc, guard, exp_lat, m;
        logic [31:0] exp_rdata, h_rdata;
        logic [1:0]  exp_resp, h_resp;
        bit          exp_to;
        slave_clear(wr);
        m = (aw_dly > w_dly) ? aw_dly : w_dly;
        exp_to = 1'b0;
        if (wr) begin
            exp_rdata = 32'h0; exp_resp = s_bresp; exp_lat = 3 + m + b_dly;
        end else begin
            exp_rdata = s_rdata; exp_resp = s_rresp; exp_lat = 3 + ar_dly + r_dly;
        end
`ifdef AXI_MASTER_TIMEOUT_EN
        if (wr && b_never) begin
            exp_to = 1'b1; exp_resp = 2'b10; exp_rdata = 32'h0; exp_lat = TO + 1;
        end
`endif
        tick();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        guard = 0;
        while (!cmd_ready && guard < 50) begin tick(); guard++; end
        check({nm, " cmd_ready"}, cmd_ready, 1'b1);
        acc_cyc = cyc;
        tick();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        guard = 0;
        while (!rsp_valid && guard < 500) begin tick(); guard++; end
        check({nm, " rsp_valid"}, rsp_valid, 1'b1);
        check({nm, " latency"}, cyc - acc_cyc, exp_lat);
        check({nm, " rdata"}, rsp_rdata, exp_rdata);
        check({nm, " resp"}, rsp_resp, exp_resp);
        check({nm, " timeout"}, rsp_timeout, exp_to);
        h_rdata = rsp_rdata; h_resp = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({nm, " hold valid"}, {rsp_valid, cmd_ready}, 2'b10);
            check({nm, " hold data"}, {rsp_rdata, rsp_resp}, {h_rdata, h_resp});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({nm, " post rsp"}, {rsp_valid, cmd_ready}, 2'b01);
        if (wr) begin
            check({nm, " aw addr"}, s_awaddr, addr);
            check({nm, " w data"}, {s_wdata, s_wstrb}, {wdata, strb});
            check({nm, " aw/w/b hs"}, {8'(aw_hs), 8'(w_hs), 8'(b_hs)}, {8'd1, 8'd1, exp_to ? 8'd0 : 8'd1});
            check({nm, " aw/w first"}, {aw_first - acc_cyc, w_first - acc_cyc}, {32'd1, 32'd1});
            check({nm, " aw/w cycles"}, {aw_vcyc, w_vcyc}, {aw_dly + 1, w_dly + 1});
            check({nm, " bready first"}, bready_first - acc_cyc, 2 + m);
        end else begin
            check({nm, " ar addr"}, s_araddr, addr);
            check({nm, " ar/r hs"}, {8'(ar_hs), 8'(r_hs)}, {8'd1, 8'd1});
            check({nm, " ar first"}, ar_first - acc_cyc, 1);
            check({nm, " ar cycles"}, ar_vcyc, ar_dly + 1);
            check({nm, " rready first"}, rready_first - acc_cyc, 2 + ar_dly);
        end
        check({nm, " protocol"}, viol, 0);
    endtask

    initial begin
        ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        slave_clear(1'b1);
        repeat (3) tick();
        check("reset cmd_ready", cmd_ready, 1'b1);
        check("reset rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 36'h0);
        check("reset axi valid/ready",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
        check("reset axi payload", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR}, 100'h0);
        ARESETN = 1'b1;

        cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn("wr zero-wait", 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0);
        cfg(3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn("wr aw delayed", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h5, 0);
        cfg(0, 2, 1, 0, 0, 2'b11, 2'b00, 32'h0);
        run_txn("wr w delayed", 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'hA, 1);
        cfg(0, 0, 0, 0, 2, 2'b00, 2'b10, 32'h1234_5678);
        run_txn("rd r wait", 1'b0, 32'h0000_001C, 32'h0, 4'h0, 0);
        cfg(0, 0, 0, 1, 0, 2'b00, 2'b01, 32'hA5A5_5A5A);
        run_txn("rd stall", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 5);

        // Reset in the middle of an unanswered read request
        cfg(0, 0, 0, 1000, 0, 2'b00, 2'b00, 32'h0);
        slave_clear(1'b0);
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0200;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("pre-reset arvalid", {M_AXI_ARVALID, M_AXI_ARREADY}, 2'b10);
        ARESETN = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0300;
        tick();
        check("mid-reset state", {M_AXI_ARVALID, M_AXI_AWVALID, cmd_ready, rsp_valid}, 4'b0010);
        tick();
        ARESETN = 1'b1; cmd_valid = 1'b0;
        tick();
        check("post-reset idle",
              {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, rsp_valid}, 5'b00010);

`ifdef AXI_MASTER_TIMEOUT_EN
        cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        b_never = 1'b1;
        run_txn("wr timeout", 1'b1, 32'h0000_0010, 32'h5555_AAAA, 4'hF, 1);
        b_never = 1'b0;
`endif

        for (int k = 0; k < 24; k++) begin
            cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            run_txn($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4lite_master.md
AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
REQ-001 Parameter AXIS_ADDR_WIDTH, 32, AXI address width.
REQ-002 Parameter AXIS_DATA_WIDTH, 32, AXI data width (32 only).
REQ-003 Parameter TIMEOUT_CYCLES, 1024, wait-cycle limit (used only with AXI_MASTER_TIMEOUT_EN).
REQ-004 ACLK  in  1  clock; all logic on rising edge.
REQ-005 ARESETN  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  AXIS_ADDR_WIDTH  target address.
REQ-009 cmd_wdata / cmd_wstrb  in  32 / 4  write data and byte strobes.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 rsp_rdata  out  32  read data (0 for writes).
REQ-012 rsp_resp  out  2  BRESP/RRESP as received.
REQ-013 rsp_timeout  out  1  transaction aborted by timeout.
REQ-014 M_AXI_AW{ADDR,PROT,VALID,READY}, W{DATA,STRB,VALID,READY}, B{RESP,VALID,READY}, AR{ADDR,PROT,VALID,READY}, R{DATA,RESP,VALID,READY}: standard AXI4-Lite master directions and widths; AWPROT=ARPROT=3'b000.

Function
REQ-015 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-016 cmd_ready = 1 only in IDLE; command captured into registers on cmd_valid&&cmd_ready.
REQ-017 IDLE -> WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0) on capture; AWVALID+WVALID (or ARVALID) asserted the next cycle, all AXI outputs registered.
REQ-018 WR_REQ: AWVALID drops the cycle after AWVALID&&AWREADY, WVALID the cycle after WVALID&&WREADY, independently; either order or simultaneous is legal; -> WR_RESP once both accepted.
REQ-019 WR_RESP: BREADY=1; on BVALID capture BRESP, -> RSP.
REQ-020 RD_REQ: ARVALID held until ARREADY, -> RD_RESP; RD_RESP: RREADY=1; on RVALID capture RDATA/RRESP, -> RSP.
REQ-021 VALID signals never deasserted before their handshake (except timeout, REQ-030); AW/W/AR payload stable while VALID.
REQ-022 RSP: rsp_valid=1, rsp_* stable until rsp_ready; -> IDLE on rsp_valid&&rsp_ready.
REQ-023 Minimum latency, zero-wait slave: cmd accept cycle N, request valid N+1, response handshake N+2, rsp_valid N+3.
REQ-024 One outstanding transaction; no AXI request issued outside WR_REQ/RD_REQ; BREADY/RREADY 0 outside WR_RESP/RD_RESP.
REQ-025 rsp_resp forwarded unmodified (OKAY/EXOKAY/SLVERR/DECERR); no retry.

Reset
REQ-026 ARESETN=0 at rising edge -> state IDLE next cycle regardless of current state, including mid-handshake.
REQ-027 Reset values: all VALID/READY outputs 0 except cmd_ready=1; rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, address/data outputs 0, timeout counter 0.
REQ-028 Command presented during reset not accepted.

Configuration
REQ-029 Macro AXI_MASTER_TIMEOUT_EN defined: counter starts at 0 on entering WR_REQ/RD_REQ, increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP, clears on entering RSP.
REQ-030 With macro, counter reaching TIMEOUT_CYCLES-1 without completion: all AXI VALID/READY drop next cycle, -> RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-031 Macro undefined: no counter, rsp_timeout tied 0, wait unbounded.

Verification
REQ-032 Write 0x0000_0004 data 0xDEAD_BEEF strb 0xF, zero-wait slave -> AW/W valid N+1, BREADY N+2, rsp_valid N+3, rsp_resp=0.
REQ-033 Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR, single B handshake.
REQ-034 Read 0x0000_001C, slave RDATA=0x1234_5678 RRESP=2'b10 after 2-cycle wait -> rsp_rdata=0x1234_5678, rsp_resp=2'b10.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0 throughout, cmd accepted the cycle after rsp handshake.
REQ-036 ARESETN=0 while ARVALID=1 and ARREADY=0 -> next cycle ARVALID=0, cmd_ready=1, no rsp_valid.
REQ-037 AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts BVALID -> rsp_valid with rsp_timeout=1, rsp_resp=2'b10, 16 cycles after entering WR_REQ.
